// File: rtl/vc_distributor.sv
// Receive side of the virtual-channel path: steers each tagged word to one of
// four VC FIFOs, holding one word under almost-full until it drains or times out.
module vc_distributor #(
    parameter int DATA_W       = 4,
    parameter int CNT_W        = 8,
    parameter int HOLD_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enb,
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        dest_in,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [3:0]        almost_full,
    output logic [3:0]        push_vchannel,
    output logic [DATA_W-1:0] data_vchannel0,
    output logic [DATA_W-1:0] data_vchannel1,
    output logic [DATA_W-1:0] data_vchannel2,
    output logic [DATA_W-1:0] data_vchannel3,
    output logic              drop_pulse,
    output logic [CNT_W-1:0]  drop_count,
    output logic [CNT_W-1:0]  sent_count0,
    output logic [CNT_W-1:0]  sent_count1,
    output logic [CNT_W-1:0]  sent_count2,
    output logic [CNT_W-1:0]  sent_count3,
    output logic              hold_busy
);

    localparam int TMR_W = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(HOLD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic [1:0]        hold_dest_q, hold_dest_d;
    logic [3:0]        push_q, push_d;
    logic              drop_q, drop_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic [DATA_W-1:0] data_q [4];
    logic [DATA_W-1:0] data_d [4];
    logic [CNT_W-1:0]  sent_q [4];
    logic [CNT_W-1:0]  sent_d [4];

    logic              push_en;
    logic [1:0]        push_dest;
    logic [DATA_W-1:0] push_data;
    logic              accept;

    assign ready_out = rst & enb & (state_q == IDLE);
    assign accept    = valid_in & ready_out;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        hold_data_d = hold_data_q;
        hold_dest_d = hold_dest_q;
        drop_cnt_d  = drop_cnt_q;
        drop_d      = 1'b0;
        push_en     = 1'b0;
        push_dest   = dest_in;
        push_data   = data_in;
        if (enb) begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (!almost_full[dest_in]) begin
                            push_en = 1'b1;
                        end else begin
                            state_d     = HOLD;
                            hold_data_d = data_in;
                            hold_dest_d = dest_in;
                            timer_d     = '0;
                        end
                    end
                end
                HOLD: begin
                    push_dest = hold_dest_q;
                    push_data = hold_data_q;
                    // A FIFO freeing on the timeout cycle still gets the word.
                    if (!almost_full[hold_dest_q]) begin
                        push_en = 1'b1;
                        state_d = IDLE;
                    end else if (timer_q == TMR_LAST) begin
                        drop_d  = 1'b1;
                        state_d = IDLE;
                        if (drop_cnt_q != CNT_MAX) begin
                            drop_cnt_d = drop_cnt_q + 1'b1;
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        push_d = '0;
        for (int i = 0; i < 4; i++) begin
            data_d[i] = data_q[i];
            sent_d[i] = sent_q[i];
            if (push_en && push_dest == 2'(i)) begin
                push_d[i] = 1'b1;
                data_d[i] = push_data;
                if (sent_q[i] != CNT_MAX) begin
                    sent_d[i] = sent_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            hold_data_q <= '0;
            hold_dest_q <= '0;
            push_q      <= '0;
            drop_q      <= 1'b0;
            drop_cnt_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
                sent_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            hold_data_q <= hold_data_d;
            hold_dest_q <= hold_dest_d;
            push_q      <= push_d;
            drop_q      <= drop_d;
            drop_cnt_q  <= drop_cnt_d;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= data_d[i];
                sent_q[i] <= sent_d[i];
            end
        end
    end

    assign push_vchannel  = push_q;
    assign drop_pulse     = drop_q;
    assign drop_count     = drop_cnt_q;
    assign hold_busy      = (state_q == HOLD);
    assign data_vchannel0 = data_q[0];
    assign data_vchannel1 = data_q[1];
    assign data_vchannel2 = data_q[2];
    assign data_vchannel3 = data_q[3];
    assign sent_count0    = sent_q[0];
    assign sent_count1    = sent_q[1];
    assign sent_count2    = sent_q[2];
    assign sent_count3    = sent_q[3];

endmodule

// File: tb/tb_vc_distributor.sv
// Directed bench for vc_distributor: vector table for reset/stream/backpressure,
// hand sequences for timeout, enable freeze, saturation and reset during hold.
module tb_vc_distributor;

    localparam int DW = 4;
    localparam int CW = 3;
    localparam int HT = 5;

    logic          clk = 1'b0;
    logic          rst, enb, valid_in;
    logic [DW-1:0] data_in;
    logic [1:0]    dest_in;
    logic [3:0]    almost_full;
    logic          ready_out, drop_pulse, hold_busy;
    logic [3:0]    push_vchannel;
    logic [DW-1:0] dv [4];
    logic [CW-1:0] sc [4];
    logic [CW-1:0] drop_count;

    int checks = 0;
    int errors = 0;

    vc_distributor #(
        .DATA_W(DW), .CNT_W(CW), .HOLD_TIMEOUT(HT)
    ) dut (
        .clk(clk), .rst(rst), .enb(enb),
        .data_in(data_in), .dest_in(dest_in),
        .valid_in(valid_in), .ready_out(ready_out),
        .almost_full(almost_full),
        .push_vchannel(push_vchannel),
        .data_vchannel0(dv[0]), .data_vchannel1(dv[1]),
        .data_vchannel2(dv[2]), .data_vchannel3(dv[3]),
        .drop_pulse(drop_pulse), .drop_count(drop_count),
        .sent_count0(sc[0]), .sent_count1(sc[1]),
        .sent_count2(sc[2]), .sent_count3(sc[3]),
        .hold_busy(hold_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, enb, vld;
        logic [3:0] data;
        logic [1:0] dest;
        logic [3:0] af;
        logic [3:0] e_push;
        logic [3:0] e_data;
        logic       e_ready, e_busy, e_drop;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(
        logic r, logic e, logic v, logic [3:0] d, logic [1:0] ds,
        logic [3:0] af, logic [3:0] ep, logic [3:0] ed,
        logic er, logic eb, logic edr);
        vec_t x;
        x.rst = r; x.enb = e; x.vld = v; x.data = d; x.dest = ds;
        x.af = af; x.e_push = ep; x.e_data = ed;
        x.e_ready = er; x.e_busy = eb; x.e_drop = edr;
        return x;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(string tag, logic [3:0] ep, logic er, logic eb, logic edr);
        chk({tag, " push"}, int'(push_vchannel), int'(ep));
        chk({tag, " ready"}, int'(ready_out), int'(er));
        chk({tag, " busy"}, int'(hold_busy), int'(eb));
        chk({tag, " drop"}, int'(drop_pulse), int'(edr));
    endtask

    task automatic drive(logic v, logic [3:0] d, logic [1:0] ds, logic [3:0] af);
        valid_in = v; data_in = d; dest_in = ds; almost_full = af;
    endtask

    initial begin
        rst = 1'b0; enb = 1'b1;
        drive(1'b0, 4'h0, 2'd0, 4'b0000);

        // rst en vld data dest af     push     data  rdy busy drop
        vt.push_back(mk(0,1,0,4'h0,2'd0,4'b0000,4'b0000,4'h0,0,0,0));
        vt.push_back(mk(0,1,0,4'h0,2'd0,4'b0000,4'b0000,4'h0,0,0,0));
        vt.push_back(mk(1,1,0,4'h0,2'd0,4'b0000,4'b0000,4'h0,1,0,0));
        vt.push_back(mk(1,1,1,4'hA,2'd0,4'b0000,4'b0001,4'hA,1,0,0));
        vt.push_back(mk(1,1,1,4'hB,2'd1,4'b0000,4'b0010,4'hB,1,0,0));
        vt.push_back(mk(1,1,1,4'hC,2'd2,4'b0000,4'b0100,4'hC,1,0,0));
        vt.push_back(mk(1,1,1,4'hD,2'd3,4'b0000,4'b1000,4'hD,1,0,0));
        vt.push_back(mk(1,1,0,4'hE,2'd1,4'b0000,4'b0000,4'h0,1,0,0));
        vt.push_back(mk(1,1,1,4'h5,2'd2,4'b0100,4'b0000,4'h0,0,1,0));
        vt.push_back(mk(1,1,0,4'hF,2'd0,4'b0100,4'b0000,4'h0,0,1,0));
        vt.push_back(mk(1,1,0,4'hF,2'd0,4'b0100,4'b0000,4'h0,0,1,0));
        vt.push_back(mk(1,1,0,4'hF,2'd0,4'b0000,4'b0100,4'h5,1,0,0));
        vt.push_back(mk(1,1,0,4'h0,2'd0,4'b0000,4'b0000,4'h0,1,0,0));
        vt.push_back(mk(1,1,1,4'h3,2'd0,4'b1110,4'b0001,4'h3,1,0,0));

        foreach (vt[n]) begin
            rst = vt[n].rst; enb = vt[n].enb;
            drive(vt[n].vld, vt[n].data, vt[n].dest, vt[n].af);
            step();
            chk_out($sformatf("vec%0d", n), vt[n].e_push,
                    vt[n].e_ready, vt[n].e_busy, vt[n].e_drop);
            for (int c = 0; c < 4; c++) begin
                if (vt[n].e_push[c])
                    chk($sformatf("vec%0d data%0d", n, c),
                        int'(dv[c]), int'(vt[n].e_data));
            end
            if (n == 1) begin
                chk("reset drop_count", int'(drop_count), 0);
                for (int c = 0; c < 4; c++)
                    chk($sformatf("reset sent%0d", c), int'(sc[c]), 0);
            end
            if (n == 7) begin
                for (int c = 0; c < 4; c++)
                    chk($sformatf("stream sent%0d", c), int'(sc[c]), 1);
            end
        end

        // Timeout drop with FIFO 1 stuck full
        drive(1'b1, 4'h7, 2'd1, 4'b0010);
        step();
        chk_out("to capture", 4'b0000, 0, 1, 0);
        valid_in = 1'b0;
        for (int k = 1; k <= HT; k++) begin
            step();
            if (k < HT) chk_out($sformatf("to wait%0d", k), 4'b0000, 0, 1, 0);
            else        chk_out("to expire", 4'b0000, 1, 0, 1);
        end
        chk("to drop_count", int'(drop_count), 1);
        step();
        chk("to pulse end", int'(drop_pulse), 0);

        // FIFO frees exactly at the timeout edge: push wins
        drive(1'b1, 4'h7, 2'd1, 4'b0010);
        step();
        valid_in = 1'b0;
        for (int k = 1; k < HT; k++) step();
        almost_full = 4'b0000;
        step();
        chk_out("edge race", 4'b0010, 1, 0, 0);
        chk("edge race data", int'(dv[1]), 7);
        chk("edge race drop_count", int'(drop_count), 1);

        // Enable freeze mid-hold preserves remaining timeout
        drive(1'b1, 4'h9, 2'd1, 4'b0010);
        step();
        valid_in = 1'b0;
        step();
        step();
        enb = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_out($sformatf("freeze%0d", k), 4'b0000, 0, 1, 0);
        end
        enb = 1'b1;
        step();
        chk_out("resume1", 4'b0000, 0, 1, 0);
        step();
        chk_out("resume2", 4'b0000, 0, 1, 0);
        step();
        chk_out("resume3", 4'b0000, 1, 0, 1);
        chk("freeze drop_count", int'(drop_count), 2);

        // Saturation of sent_count3
        drive(1'b1, 4'h0, 2'd3, 4'b0000);
        for (int k = 0; k < 10; k++) begin
            data_in = 4'(k);
            step();
        end
        valid_in = 1'b0;
        step();
        chk("sat sent3", int'(sc[3]), 7);
        chk("sent0 total", int'(sc[0]), 2);
        chk("sent1 total", int'(sc[1]), 2);
        chk("sent2 total", int'(sc[2]), 2);

        // Reset while holding: silent discard
        drive(1'b1, 4'hE, 2'd3, 4'b1000);
        step();
        valid_in = 1'b0;
        step();
        chk("rsthold busy", int'(hold_busy), 1);
        rst = 1'b0;
        step();
        chk_out("rsthold rst", 4'b0000, 0, 0, 0);
        chk("rsthold drop_count", int'(drop_count), 0);
        chk("rsthold sent3", int'(sc[3]), 0);
        rst = 1'b1;
        for (int k = 0; k < HT + 2; k++) begin
            step();
            chk_out($sformatf("post rst%0d", k), 4'b0000, 1, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
